// File: rtl/mult_div_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - MD_OP_* : operation encodings carried on the op port
//   - md_state_e : controller state encoding
//   - width helpers for the W / 2W result path
package mult_div_iter_pkg;

   localparam logic [2:0] MD_OP_MULT  = 3'd0;
   localparam logic [2:0] MD_OP_MULTU = 3'd1;
   localparam logic [2:0] MD_OP_DIV   = 3'd2;
   localparam logic [2:0] MD_OP_DIVU  = 3'd3;
   localparam logic [2:0] MD_OP_MADD  = 3'd4;
   localparam logic [2:0] MD_OP_MADDU = 3'd5;
   localparam logic [2:0] MD_OP_MSUB  = 3'd6;
   localparam logic [2:0] MD_OP_MSUBU = 3'd7;

   localparam int MD_W_DEFAULT = 32;

   typedef enum logic [2:0] {
      MD_ST_IDLE = 3'd0,
      MD_ST_MUL  = 3'd1,
      MD_ST_DIV  = 3'd2,
      MD_ST_FIX  = 3'd3,
      MD_ST_DONE = 3'd4
   } md_state_e;

   function automatic int md_res_w(input int w);
      return 2 * w;
   endfunction

   function automatic logic md_is_div(input logic [2:0] op);
      return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
   endfunction

   // Signed flavours: MULT, DIV, MADD, MSUB (all even encodings)
   function automatic logic md_is_signed(input logic [2:0] op);
      return (op == MD_OP_MULT) || (op == MD_OP_DIV) ||
             (op == MD_OP_MADD) || (op == MD_OP_MSUB);
   endfunction

endpackage

// File: rtl/mult_div_iter_div_core.sv
// Iterative restoring divider working on operand magnitudes.
// Retires DIV_STEP quotient bits per cycle, W/DIV_STEP cycles per divide.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start               load operands and begin (divisor must be non-zero)
//   clear               abandon the divide in progress
//   is_signed           take magnitudes of two's-complement operands
//   dividend, divisor   W-bit operands, sampled on start
//   last                high during the final iteration cycle
//   quotient, remainder magnitude results, valid the cycle after last
module mult_div_iter_div_core #(
   parameter int W        = 32,
   parameter int DIV_STEP = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         clear,
   input  logic         is_signed,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         last,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder
);

   localparam int STEPS = W / DIV_STEP;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

   logic          active;
   logic [CW-1:0] step_cnt;
   logic [W-1:0]  rem_q;
   logic [W-1:0]  quo_q;
   logic [W-1:0]  dsr_q;
   logic [W-1:0]  dvd_mag;
   logic [W-1:0]  dsr_mag;
   logic [W:0]    sh_t;
   logic [W-1:0]  r_t;
   logic [W-1:0]  q_t;

   assign dvd_mag = (is_signed && dividend[W-1]) ? (~dividend + 1'b1) : dividend;
   assign dsr_mag = (is_signed && divisor[W-1])  ? (~divisor + 1'b1)  : divisor;

   assign last      = active && (step_cnt == '0);
   assign quotient  = quo_q;
   assign remainder = rem_q;

   // quo_q starts as the dividend and shifts quotient bits in from the right
   always_comb begin
      r_t  = rem_q;
      q_t  = quo_q;
      sh_t = '0;
      for (int i = 0; i < DIV_STEP; i++) begin
         sh_t = {r_t, q_t[W-1]};
         q_t  = {q_t[W-2:0], 1'b0};
         if (sh_t >= {1'b0, dsr_q}) begin
            sh_t   = sh_t - {1'b0, dsr_q};
            q_t[0] = 1'b1;
         end
         r_t = sh_t[W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         active   <= 1'b0;
         step_cnt <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dsr_q    <= '0;
      end else if (clear) begin
         active   <= 1'b0;
         step_cnt <= '0;
      end else if (start) begin
         active   <= 1'b1;
         step_cnt <= CW'(STEPS - 1);
         rem_q    <= '0;
         quo_q    <= dvd_mag;
         dsr_q    <= dsr_mag;
      end else if (active) begin
         rem_q <= r_t;
         quo_q <= q_t;
         if (step_cnt == '0) begin
            active <= 1'b0;
         end else begin
            step_cnt <= step_cnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/mult_div_iter.sv
// Multi-cycle multiply/divide unit for the EX-stage HI/LO path.
// EX raises start and stalls until done; ack consumes the result.
// Optional build macro: MULDIV_ACCUM_EN enables MADD/MSUB accumulation
// into {hi_in, lo_in}; without it ops 4/6 act as MULT and 5/7 as MULTU.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   start, op             request and operation code (MD_OP_*)
//   operand_1, operand_2  multiplicand/dividend, multiplier/divisor
//   hi_in, lo_in          accumulator halves, sampled at start
//   ack                   result consumed (only honoured in DONE)
//   flush                 cancel current operation
//   busy, done            MUL/DIV/FIX in progress, result valid
//   div_zero              current result came from a divide by zero
//   result                {HI, LO}
//
// state | meaning
// IDLE  | waiting for start
// MUL   | product travelling down the MUL_STAGES register chain
// DIV   | div_core iterating
// FIX   | apply quotient/remainder signs
// DONE  | result held until ack
module mult_div_iter
   import mult_div_iter_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DIV_STEP   = 1,
   parameter int MUL_STAGES = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [2:0]              op,
   input  logic [DATA_WIDTH-1:0]   operand_1,
   input  logic [DATA_WIDTH-1:0]   operand_2,
   input  logic [DATA_WIDTH-1:0]   hi_in,
   input  logic [DATA_WIDTH-1:0]   lo_in,
   input  logic                    ack,
   input  logic                    flush,
   output logic                    busy,
   output logic                    done,
   output logic                    div_zero,
   output logic [2*DATA_WIDTH-1:0] result
);

   localparam int W   = DATA_WIDTH;
   localparam int RW  = md_res_w(DATA_WIDTH);
   localparam int MCW = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;

   if (!((DIV_STEP == 1) || (DIV_STEP == 2) || (DIV_STEP == 4)) ||
       ((W % DIV_STEP) != 0) || (MUL_STAGES < 1)) begin : g_bad_param
      $error("mult_div_iter: illegal DIV_STEP/MUL_STAGES for DATA_WIDTH");
   end

   md_state_e      state;
   logic [MCW-1:0] mul_cnt;
   logic [RW-1:0]  mul_pipe [MUL_STAGES];
   logic           accept;
   logic           div_start;
   logic           div_last;
   logic           op_div;
   logic           op_signed;
   logic           quo_neg_q;
   logic           rem_neg_q;
   logic [RW-1:0]  a_ext;
   logic [RW-1:0]  b_ext;
   logic [RW-1:0]  prod;
   logic [RW-1:0]  mul_res;
   logic [W-1:0]   div_quo;
   logic [W-1:0]   div_rem;
   logic [W-1:0]   quo_fix;
   logic [W-1:0]   rem_fix;

   assign op_div    = md_is_div(op);
   assign op_signed = md_is_signed(op);
   assign accept    = !flush && start &&
                      ((state == MD_ST_IDLE) || ((state == MD_ST_DONE) && ack));
   assign div_start = accept && op_div && (operand_2 != '0);

   // 2W x 2W product truncated to 2W is correct mod 2^(2W) for both signednesses
   assign a_ext = op_signed ? {{W{operand_1[W-1]}}, operand_1} : {{W{1'b0}}, operand_1};
   assign b_ext = op_signed ? {{W{operand_2[W-1]}}, operand_2} : {{W{1'b0}}, operand_2};
   assign prod  = a_ext * b_ext;

`ifdef MULDIV_ACCUM_EN
   always_comb begin
      mul_res = prod;
      case (op)
         MD_OP_MADD, MD_OP_MADDU: mul_res = {hi_in, lo_in} + prod;
         MD_OP_MSUB, MD_OP_MSUBU: mul_res = {hi_in, lo_in} - prod;
         default:                 mul_res = prod;
      endcase
   end
`else
   logic unused_acc;
   assign unused_acc = ^{hi_in, lo_in};
   assign mul_res    = prod;
`endif

   // Product enters at accept; stage MUL_STAGES-1 is read on the last MUL cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < MUL_STAGES; i++) begin
            mul_pipe[i] <= '0;
         end
      end else if (accept || (state == MD_ST_MUL)) begin
         mul_pipe[0] <= mul_res;
         for (int i = 1; i < MUL_STAGES; i++) begin
            mul_pipe[i] <= mul_pipe[i-1];
         end
      end
   end

   mult_div_iter_div_core #(
      .W        (W),
      .DIV_STEP (DIV_STEP)
   ) u_div_core (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start),
      .clear     (flush),
      .is_signed (op_signed),
      .dividend  (operand_1),
      .divisor   (operand_2),
      .last      (div_last),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   assign quo_fix = quo_neg_q ? (~div_quo + 1'b1) : div_quo;
   assign rem_fix = rem_neg_q ? (~div_rem + 1'b1) : div_rem;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= MD_ST_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         div_zero  <= 1'b0;
         result    <= '0;
         mul_cnt   <= '0;
         quo_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
      end else if (flush) begin
         state    <= MD_ST_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         mul_cnt  <= '0;
      end else if (accept) begin
         div_zero  <= 1'b0;
         quo_neg_q <= op_signed && (operand_1[W-1] ^ operand_2[W-1]);
         rem_neg_q <= op_signed && operand_1[W-1];
         if (op_div && (operand_2 == '0)) begin
            state    <= MD_ST_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            div_zero <= 1'b1;
            result   <= {operand_1, {W{1'b1}}};
         end else if (op_div) begin
            state <= MD_ST_DIV;
            busy  <= 1'b1;
            done  <= 1'b0;
         end else begin
            state   <= MD_ST_MUL;
            busy    <= 1'b1;
            done    <= 1'b0;
            mul_cnt <= MCW'(MUL_STAGES - 1);
         end
      end else begin
         case (state)
            MD_ST_IDLE: begin
               busy <= 1'b0;
               done <= 1'b0;
            end
            MD_ST_MUL: begin
               if (mul_cnt == '0) begin
                  state  <= MD_ST_DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  result <= mul_pipe[MUL_STAGES-1];
               end else begin
                  mul_cnt <= mul_cnt - 1'b1;
               end
            end
            MD_ST_DIV: begin
               if (div_last) begin
                  state <= MD_ST_FIX;
               end
            end
            MD_ST_FIX: begin
               state  <= MD_ST_DONE;
               busy   <= 1'b0;
               done   <= 1'b1;
               result <= {rem_fix, quo_fix};
            end
            MD_ST_DONE: begin
               if (ack) begin
                  state <= MD_ST_IDLE;
                  done  <= 1'b0;
               end
            end
            default: begin
               state <= MD_ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_iter.sv
module tb_mult_div_iter;

   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           start = 1'b0;
   logic [2:0]     op = 3'd0;
   logic [W-1:0]   operand_1 = '0;
   logic [W-1:0]   operand_2 = '0;
   logic [W-1:0]   hi_in = '0;
   logic [W-1:0]   lo_in = '0;
   logic           ack = 1'b0;
   logic           flush = 1'b0;
   logic           busy;
   logic           done;
   logic           div_zero;
   logic [2*W-1:0] result;

   int checks = 0;
   int failures = 0;
   logic [2*W-1:0] exp_last = '0;

   always #5 clk = ~clk;

   mult_div_iter #(
      .DATA_WIDTH (W),
      .DIV_STEP   (1),
      .MUL_STAGES (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .operand_1 (operand_1),
      .operand_2 (operand_2),
      .hi_in     (hi_in),
      .lo_in     (lo_in),
      .ack       (ack),
      .flush     (flush),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero),
      .result    (result)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one accept cycle; returns in cycle 1 of the operation
   task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] h, input logic [W-1:0] l);
      op = o; operand_1 = a; operand_2 = b; hi_in = h; lo_in = l;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 1;
      while (done !== 1'b1 && cyc < 200) begin
         step();
         cyc++;
      end
      if (done !== 1'b1) cyc = -1;
   endtask

   task automatic do_ack();
      ack = 1'b1;
      step();
      ack = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({busy, done, div_zero} !== 3'b000 || result !== '0) begin
         failures++;
         $display("FAIL reset_outputs got busy/done/dz=%b result=%h exp 000 and 0", {busy, done, div_zero}, result);
      end
      @(negedge clk);
      rst = 1'b1;
      step();
      checks++;
      if ({busy, done} !== 2'b00) begin
         failures++;
         $display("FAIL reset_release got busy/done=%b exp 00", {busy, done});
      end
   endtask

   task automatic test_mult();
      int cyc;
      issue(3'd0, 32'hFFFF_FFFD, 32'd7, '0, '0);
      checks++;
      if ({busy, done} !== 2'b10) begin
         failures++;
         $display("FAIL mult_cycle1 got busy/done=%b exp 10", {busy, done});
      end
      step();
      checks++;
      if ({busy, done} !== 2'b10) begin
         failures++;
         $display("FAIL mult_cycle2 got busy/done=%b exp 10", {busy, done});
      end
      step();
      cyc = 3;
      checks++;
      if ({busy, done} !== 2'b01) begin
         failures++;
         $display("FAIL mult_cycle3 got busy/done=%b exp 01 (cycle %0d)", {busy, done}, cyc);
      end
      checks++;
      if (result !== 64'hFFFF_FFFF_FFFF_FFEB) begin
         failures++;
         $display("FAIL mult_result got %h exp %h", result, 64'hFFFF_FFFF_FFFF_FFEB);
      end
      do_ack();
   endtask

   task automatic test_divu_hold();
      int cyc;
      issue(3'd3, 32'd100, 32'd7, '0, '0);
      cyc = 1;
      while (done !== 1'b1 && cyc < 200) begin
         // start and ack while busy must both be ignored
         if (cyc == 5) begin
            start = 1'b1; ack = 1'b1; op = 3'd0; operand_1 = 32'd1; operand_2 = 32'd1;
         end
         step();
         start = 1'b0; ack = 1'b0;
         cyc++;
      end
      checks++;
      if (cyc !== 34) begin
         failures++;
         $display("FAIL divu_latency got %0d exp 34", cyc);
      end
      checks++;
      if (result !== {32'd2, 32'd14}) begin
         failures++;
         $display("FAIL divu_result got %h exp %h", result, {32'd2, 32'd14});
      end
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (done !== 1'b1 || result !== {32'd2, 32'd14}) begin
            failures++;
            $display("FAIL divu_hold cycle %0d got done=%b result=%h exp 1 %h", i, done, result, {32'd2, 32'd14});
         end
      end
      do_ack();
      checks++;
      if ({busy, done} !== 2'b00) begin
         failures++;
         $display("FAIL divu_ack_drop got busy/done=%b exp 00", {busy, done});
      end
   endtask

   task automatic test_div_signed();
      int cyc;
      logic [2*W-1:0] exp;
      issue(3'd2, 32'hFFFF_FFF9, 32'd2, '0, '0);
      wait_done(cyc);
      exp = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
      checks++;
      if (cyc !== 34 || result !== exp) begin
         failures++;
         $display("FAIL div_neg7_by_2 got cyc=%0d result=%h exp 34 %h", cyc, result, exp);
      end
      do_ack();
      issue(3'd2, 32'd7, 32'hFFFF_FFFE, '0, '0);
      wait_done(cyc);
      exp = {32'd1, 32'hFFFF_FFFD};
      checks++;
      if (result !== exp) begin
         failures++;
         $display("FAIL div_7_by_neg2 got %h exp %h", result, exp);
      end
      do_ack();
      issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, '0, '0);
      wait_done(cyc);
      exp = {32'd0, 32'h8000_0000};
      checks++;
      if (result !== exp || div_zero !== 1'b0) begin
         failures++;
         $display("FAIL div_minneg_by_neg1 got %h dz=%b exp %h dz=0", result, div_zero, exp);
      end
      do_ack();
   endtask

   task automatic test_div_zero();
      int cyc;
      issue(3'd2, 32'd5, 32'd0, '0, '0);
      checks++;
      if (done !== 1'b1 || div_zero !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL divzero_flags got done=%b dz=%b busy=%b exp 1 1 0", done, div_zero, busy);
      end
      checks++;
      if (result !== {32'd5, 32'hFFFF_FFFF}) begin
         failures++;
         $display("FAIL divzero_result got %h exp %h", result, {32'd5, 32'hFFFF_FFFF});
      end
      do_ack();
      checks++;
      if (div_zero !== 1'b1 || done !== 1'b0) begin
         failures++;
         $display("FAIL divzero_after_ack got dz=%b done=%b exp 1 0", div_zero, done);
      end
      issue(3'd0, 32'd2, 32'd3, '0, '0);
      checks++;
      if (div_zero !== 1'b0) begin
         failures++;
         $display("FAIL divzero_clear got %b exp 0", div_zero);
      end
      wait_done(cyc);
      checks++;
      if (cyc !== 3 || result !== 64'd6) begin
         failures++;
         $display("FAIL mult_after_divzero got cyc=%0d result=%h exp 3 %h", cyc, result, 64'd6);
      end
      do_ack();
   endtask

   task automatic test_accum();
      int cyc;
      logic [2*W-1:0] exp;
`ifdef MULDIV_ACCUM_EN
      exp = 64'h0000_0001_0000_0000;
`else
      exp = 64'd1;
`endif
      issue(3'd5, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF);
      wait_done(cyc);
      checks++;
      if (cyc !== 3 || result !== exp) begin
         failures++;
         $display("FAIL maddu got cyc=%0d result=%h exp 3 %h", cyc, result, exp);
      end
      do_ack();
`ifdef MULDIV_ACCUM_EN
      exp = 64'hFFFF_FFFF_FFFF_FFFA;
`else
      exp = 64'd6;
`endif
      issue(3'd6, 32'd2, 32'd3, 32'd0, 32'd0);
      wait_done(cyc);
      checks++;
      if (result !== exp) begin
         failures++;
         $display("FAIL msub got %h exp %h", result, exp);
      end
      do_ack();
`ifdef MULDIV_ACCUM_EN
      exp = 64'd5;
`else
      exp = 64'hFFFF_FFFF_FFFF_FFFB;
`endif
      issue(3'd4, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'd10);
      wait_done(cyc);
      checks++;
      if (result !== exp) begin
         failures++;
         $display("FAIL madd_signed got %h exp %h", result, exp);
      end
      exp_last = exp;
      do_ack();
   endtask

   task automatic test_flush();
      int seen;
      issue(3'd3, 32'd1000, 32'd3, '0, '0);
      for (int i = 0; i < 9; i++) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      checks++;
      if ({busy, done} !== 2'b00) begin
         failures++;
         $display("FAIL flush_idle got busy/done=%b exp 00", {busy, done});
      end
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) seen++;
         step();
      end
      checks++;
      if (seen !== 0) begin
         failures++;
         $display("FAIL flush_no_done got %0d done cycles exp 0", seen);
      end
      checks++;
      if (result !== exp_last) begin
         failures++;
         $display("FAIL flush_result_kept got %h exp %h", result, exp_last);
      end
   endtask

   task automatic test_reset_mid();
      issue(3'd0, 32'd5, 32'd5, '0, '0);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_busy got %b exp 1", busy);
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({busy, done, div_zero} !== 3'b000 || result !== '0) begin
         failures++;
         $display("FAIL rstmid_async got flags=%b result=%h exp 000 0", {busy, done, div_zero}, result);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) step();
      checks++;
      if (done !== 1'b0 || result !== '0) begin
         failures++;
         $display("FAIL rstmid_no_partial got done=%b result=%h exp 0 0", done, result);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      issue(3'd1, 32'd3, 32'd4, '0, '0);
      wait_done(cyc);
      checks++;
      if (cyc !== 3 || result !== 64'd12) begin
         failures++;
         $display("FAIL b2b_multu got cyc=%0d result=%h exp 3 %h", cyc, result, 64'd12);
      end
      op = 3'd3; operand_1 = 32'd9; operand_2 = 32'd2;
      start = 1'b1; ack = 1'b1;
      step();
      start = 1'b0; ack = 1'b0;
      checks++;
      if ({busy, done} !== 2'b10) begin
         failures++;
         $display("FAIL b2b_accept got busy/done=%b exp 10", {busy, done});
      end
      wait_done(cyc);
      checks++;
      if (cyc !== 34 || result !== {32'd1, 32'd4}) begin
         failures++;
         $display("FAIL b2b_divu got cyc=%0d result=%h exp 34 %h", cyc, result, {32'd1, 32'd4});
      end
      do_ack();
   endtask

   initial begin
      test_reset();
      test_mult();
      test_divu_hold();
      test_div_signed();
      test_div_zero();
      test_accum();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1);
   end

endmodule

// File: doc/mult_div_iter.md
Name: mult_div_iter

Overview:
Parametrised multi-cycle multiply/divide unit feeding the EX stage's HI/LO path. It supplies the 2×DATA_WIDTH result and completion flag that EX uses for MULT/DIV stall control. Adds an iterative divider with configurable radix, a pipelined multiplier with configurable depth, MADD/MSUB accumulation, and flush/cancel. It sits beside EX; EX asserts start and holds its stall request until done.

Parameters:
DATA_WIDTH, 32, operand width W; result is 2W.
DIV_STEP, 1, quotient bits retired per divide cycle; legal values 1, 2, 4; must divide W.
MUL_STAGES, 2, cycles spent in the MUL state (≥1).

Ports:
clk  in  1  clock.
rst  in  1  asynchronous active-low reset.
start  in  1  request a new operation.
op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
operand_1  in  W  multiplicand / dividend.
operand_2  in  W  multiplier / divisor.
hi_in  in  W  accumulator high half, sampled at start.
lo_in  in  W  accumulator low half, sampled at start.
ack  in  1  EX stage advances; consumes the result.
flush  in  1  cancel the operation (exception/eret).
busy  out  1  high in MUL, DIV, FIX.
done  out  1  high in DONE.
div_zero  out  1  the DIV/DIVU that produced the current result had divisor 0.
result  out  2W  {HI, LO}.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; busy, done, div_zero = 0; result = 0; counters = 0.
- States: IDLE, MUL, DIV, FIX, DONE.
- Acceptance: start is accepted in IDLE, or in DONE when ack is high in the same cycle (back-to-back). Start in MUL/DIV/FIX is ignored. Operands, op, hi_in and lo_in are latched at acceptance.
- flush has priority over start and ack. In any state, flush returns the unit to IDLE on the next edge; done never rises for the cancelled operation; result keeps its last value.
- MUL path (ops 0, 1, 4–7):
  - Stays in MUL for MUL_STAGES cycles, then DONE.
  - done is high at cycle MUL_STAGES+1, counting the accept cycle as 0.
  - Signed ops (0, 4, 6) use a 2W signed product; the others use an unsigned product.
  - MADD/MADDU: result = {hi,lo} + product. MSUB/MSUBU: result = {hi,lo} − product. Both wrap modulo 2^(2W).
- DIV path (ops 2, 3):
  - Non-restoring or restoring division on magnitudes, DIV_STEP quotient bits per cycle, W/DIV_STEP cycles in DIV, then one FIX cycle, then DONE.
  - done is high at cycle W/DIV_STEP+2.
  - FIX for signed division: the quotient is negated when the operand signs differ; the remainder takes the dividend's sign.
  - result = {remainder, quotient}.
  - Signed most-negative / −1: quotient = 0x80000000 (wraps), remainder = 0.
- Divisor zero: accept goes directly to DONE, so done is high at cycle 1. Result: LO = all ones, HI = dividend. div_zero = 1 for that result. div_zero clears on the next accept or flush.
- DONE: done and result are held stable until ack. ack without start returns the unit to IDLE and drops done next cycle.
- ack outside DONE is ignored.
- Reset mid-operation aborts immediately; no partial result is visible.

Optional Feature:
MULDIV_ACCUM_EN:
- Defined: ops 4–7 accumulate as specified above.
- Undefined: the accumulator adder/subtractor is not built. hi_in and lo_in are unused. Ops 4 and 6 behave as MULT; ops 5 and 7 behave as MULTU.

Decomposition:
- Shared package holds the op encodings (MD_OP_*), the state encoding, and the W/2W width macros.
- The iterative divider is one natural sub-module, div_core. It contains the magnitude datapath, the step counter and DIV_STEP-wide partial-remainder logic, with start/done handshake to the parent FSM.
- The multiplier stays inline as a MUL_STAGES-deep register chain.

Test Plan (W=32, DIV_STEP=1, MUL_STAGES=2):
- MULT, op1=0xFFFFFFFD (−3), op2=7 → result 0xFFFFFFFF_FFFFFFEB, done at cycle 3, busy cycles 1–2.
- DIVU 100/7 → result {0x00000002, 0x0000000E}, done at cycle 34; hold ack low 5 cycles → result stable; ack → done low next cycle.
- DIV 0xFFFFFFF9 (−7) / 2 → LO 0xFFFFFFFD, HI 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO 0x80000000, HI 0.
- DIV 5/0 → done at cycle 1, div_zero=1, result {0x00000005, 0xFFFFFFFF}; next accepted MULT → div_zero=0.
- MADDU hi_in=0, lo_in=0xFFFFFFFF, op1=op2=1 → result 0x00000001_00000000. MSUB hi=lo=0, 2×3 → 0xFFFFFFFF_FFFFFFFA. With MULTDIV_ACCUM_EN undefined, both behave as plain multiply.
- flush at cycle 10 of a DIVU → IDLE at cycle 11, done never asserts; rst pulsed low mid-MUL → outputs zero immediately. A start in DONE with ack high → new op accepted, done drops for exactly the new latency.
